// File: rtl/vga_vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter and its clients: display fetch, host port,
// clear-screen control and the single VRAM port.
interface vga_vram_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;

    logic              clr_start;
    logic              clr_busy;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  disp_req, disp_addr,
        input  host_req, host_we, host_addr, host_wdata,
        input  clr_start,
        input  ram_rdata,
        output disp_data, disp_valid,
        output host_ack, host_rdata,
        output clr_busy,
        output ram_addr, ram_wdata, ram_we
    );

    modport master (
        output disp_req, disp_addr,
        output host_req, host_we, host_addr, host_wdata,
        output clr_start,
        output ram_rdata,
        input  disp_data, disp_valid,
        input  host_ack, host_rdata,
        input  clr_busy,
        input  ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display fetch > clear-screen engine > host, one RAM
// access per cycle, grant tag pipelined two stages to route read data back.
module vga_vram_arbiter #(
    parameter int                RES_X_MAX = 80,
    parameter int                RES_Y_MAX = 25,
    parameter int                ADDR_W    = 11,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] CLR_CHAR  = 8'h20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    vga_vram_arbiter_if.slave bus
);

    localparam int unsigned       NUM_CELLS = RES_X_MAX * RES_Y_MAX;
    localparam logic [ADDR_W-1:0] CELLS_AW  = ADDR_W'(NUM_CELLS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CELLS - 1);

    typedef enum logic [2:0] {
        GNT_NONE,
        GNT_DISP,
        GNT_CLR,
        GNT_HOST_RD,
        GNT_HOST_WR
    } gnt_t;

    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clr_state_t;

    clr_state_t        clr_state, clr_state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              clr_busy;

    gnt_t              gnt, tag1, tag2;
    logic              oor1, oor2;
    logic              host_busy, host_busy_nxt;
    logic              host_elig, host_oor, host_gnt;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_nxt;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_nxt;
    logic              ram_we_q, ram_we_nxt;

    logic [DATA_W-1:0] disp_data_q;
    logic              disp_valid_q;
    logic              host_ack_q, host_ack_nxt;
    logic [DATA_W-1:0] host_rdata_q;

    assign clr_busy = (clr_state == CLR_RUN);

    // A display request is served in the cycle it arrives: its RAM cycle is
    // registered at N+1 and the fetched byte returns at N+3, whatever else is pending.
    always_comb begin
        host_oor  = (bus.host_addr >= CELLS_AW);
        host_elig = bus.host_req && !host_busy && !host_ack_q && !clr_busy;
        gnt       = GNT_NONE;
        if (bus.disp_req) begin
            gnt = GNT_DISP;
        end else if (clr_busy) begin
            gnt = GNT_CLR;
        end else if (host_elig) begin
            gnt = bus.host_we ? GNT_HOST_WR : GNT_HOST_RD;
        end
        host_gnt = (gnt == GNT_HOST_RD) || (gnt == GNT_HOST_WR);
    end

    always_comb begin
        clr_state_nxt = clr_state;
        clr_cnt_nxt   = clr_cnt;
        case (clr_state)
            CLR_IDLE: begin
                if (bus.clr_start) begin
                    clr_state_nxt = CLR_RUN;
                    clr_cnt_nxt   = '0;
                end
            end
            CLR_RUN: begin
                if (gnt == GNT_CLR) begin
                    if (clr_cnt == LAST_ADDR) begin
                        clr_state_nxt = CLR_IDLE;
                        clr_cnt_nxt   = '0;
                    end else begin
                        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                    end
                end
            end
            default: begin
                clr_state_nxt = CLR_IDLE;
                clr_cnt_nxt   = '0;
            end
        endcase
    end

    // Out-of-range host accesses still occupy a grant slot so the ack timing is
    // unchanged, but never touch the RAM port.
    always_comb begin
        ram_addr_nxt  = ram_addr_q;
        ram_wdata_nxt = ram_wdata_q;
        ram_we_nxt    = 1'b0;
        case (gnt)
            GNT_DISP: begin
                ram_addr_nxt = bus.disp_addr;
            end
            GNT_CLR: begin
                ram_addr_nxt  = clr_cnt;
                ram_wdata_nxt = CLR_CHAR;
                ram_we_nxt    = 1'b1;
            end
            GNT_HOST_WR: begin
                if (!host_oor) begin
                    ram_addr_nxt  = bus.host_addr;
                    ram_wdata_nxt = bus.host_wdata;
                    ram_we_nxt    = 1'b1;
                end
            end
            GNT_HOST_RD: begin
                if (!host_oor) begin
                    ram_addr_nxt = bus.host_addr;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        host_ack_nxt  = (tag1 == GNT_HOST_WR) || (tag2 == GNT_HOST_RD);
        host_busy_nxt = host_busy;
        if (host_gnt) begin
            host_busy_nxt = 1'b1;
        end else if (host_ack_nxt) begin
            host_busy_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clr_state <= CLR_IDLE;
            clr_cnt   <= '0;
        end else begin
            clr_state <= clr_state_nxt;
            clr_cnt   <= clr_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            tag1        <= GNT_NONE;
            tag2        <= GNT_NONE;
            oor1        <= 1'b0;
            oor2        <= 1'b0;
            host_busy   <= 1'b0;
        end else begin
            ram_addr_q  <= ram_addr_nxt;
            ram_wdata_q <= ram_wdata_nxt;
            ram_we_q    <= ram_we_nxt;
            tag1        <= gnt;
            tag2        <= tag1;
            oor1        <= host_gnt && host_oor;
            oor2        <= oor1;
            host_busy   <= host_busy_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            disp_valid_q <= (tag2 == GNT_DISP);
            if (tag2 == GNT_DISP) begin
                disp_data_q <= bus.ram_rdata;
            end
            host_ack_q <= host_ack_nxt;
            if (tag2 == GNT_HOST_RD) begin
                host_rdata_q <= oor2 ? '0 : bus.ram_rdata;
            end
        end
    end

    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.host_ack   = host_ack_q;
    assign bus.host_rdata = host_rdata_q;
    assign bus.clr_busy   = clr_busy;

endmodule
